// File: rtl/button_event_scheduler_pkg.sv
// Shared types and default timings for the button event scheduler.
// The event kind encoding travels with each event to the consumer.
package button_sched_pkg;

    typedef enum logic {EVT_PRESS = 1'b0, EVT_REPEAT = 1'b1} evt_kind_t;

    localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD = 10_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_scheduler_if.sv
// Button inputs and the event stream between the scheduler and its consumer.
// The slave side is the scheduler; the master side drives the buttons and ready.
interface button_event_scheduler_if #(parameter int FIELDS = 4);
    localparam int IW = $clog2(FIELDS);

    logic [FIELDS-1:0] pulses_in;
    logic [FIELDS-1:0] held_in;
    logic [FIELDS-1:0] mask_in;
    logic              evt_valid_out;
    logic              evt_ready_in;
    logic [IW-1:0]     evt_id_out;
    logic              evt_repeat_out;
    logic              dropped_out;

    modport master (
        output pulses_in, held_in, mask_in, evt_ready_in,
        input  evt_valid_out, evt_id_out, evt_repeat_out, dropped_out
    );

    modport slave (
        input  pulses_in, held_in, mask_in, evt_ready_in,
        output evt_valid_out, evt_id_out, evt_repeat_out, dropped_out
    );
endinterface

// File: rtl/button_event_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first request strictly after ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);
    int            w_j;
    logic [IW-1:0] w_idx;

    // Scan farthest-first so the nearest requester after ptr is the last write.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        w_j         = 0;
        w_idx       = '0;
        for (int k = N; k >= 1; k--) begin
            w_j   = (int'(ptr) + k) % N;
            w_idx = IW'(w_j);
            if (en && req[w_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = w_idx;
            end
        end
    end
endmodule

// File: rtl/button_event_scheduler.sv
// Collects press pulses and auto-repeat events per button and serialises them
// round-robin onto one valid/ready event stream with a single output register.
module button_event_scheduler
    import button_sched_pkg::*;
#(
    parameter int          FIELDS        = 4,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    button_event_scheduler_if.slave  bus
);
    localparam int          IW   = $clog2(FIELDS);
    localparam int unsigned CMAX = max_u(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int          CW   = $clog2(CMAX + 1);

    logic [FIELDS-1:0] w_pend, w_kind, w_req, w_gnt, w_drop;
    logic              w_gv, w_load;
    logic [IW-1:0]     w_gidx;

    logic              r_valid, r_rep, r_drop;
    logic [IW-1:0]     r_id, r_ptr;

    assign w_load = !r_valid || bus.evt_ready_in;
    assign w_req  = w_pend & ~bus.mask_in;

    rr_arbiter #(.N(FIELDS)) u_arb (
        .req         (w_req),
        .ptr         (r_ptr),
        .en          (w_load),
        .grant_valid (w_gv),
        .grant_idx   (w_gidx)
    );

    for (genvar i = 0; i < FIELDS; i++) begin : g_field
        logic [CW-1:0] r_cnt;
        logic          r_phase, r_pend, r_kind;
        logic [CW-1:0] w_tgt;
        logic          w_act, w_hit;

        assign w_act     = bus.held_in[i] && !bus.mask_in[i];
        assign w_tgt     = r_phase ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY);
        assign w_hit     = (REPEAT_DELAY != 0) && w_act && (r_cnt == w_tgt - CW'(1));
        assign w_gnt[i]  = w_gv && (w_gidx == IW'(i));
        assign w_drop[i] = !bus.mask_in[i] && bus.pulses_in[i] && r_pend && !w_gnt[i];
        assign w_pend[i] = r_pend;
        assign w_kind[i] = r_kind;

        // Counter stops at target-1 and reloads, so it never wraps.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (!w_act || REPEAT_DELAY == 0) begin
                r_cnt   <= '0;
                r_phase <= 1'b0;
            end else if (w_hit) begin
                r_cnt   <= '0;
                r_phase <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + CW'(1);
            end
        end

        // A press always wins over a repeat; a repeat onto a live pending bit is absorbed.
        always_ff @(posedge clk_in or posedge rst_in) begin
            if (rst_in) begin
                r_pend <= 1'b0;
                r_kind <= EVT_PRESS;
            end else if (bus.mask_in[i]) begin
                r_pend <= 1'b0;
            end else if (bus.pulses_in[i]) begin
                r_pend <= 1'b1;
                r_kind <= EVT_PRESS;
            end else if (w_hit) begin
                if (!r_pend || w_gnt[i]) begin
                    r_pend <= 1'b1;
                    r_kind <= EVT_REPEAT;
                end
            end else if (w_gnt[i]) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_rep   <= 1'b0;
            r_ptr   <= IW'(FIELDS - 1);
            r_drop  <= 1'b0;
        end else begin
            r_drop <= |w_drop;
            if (w_load) begin
                r_valid <= w_gv;
                if (w_gv) begin
                    r_id  <= w_gidx;
                    r_rep <= w_kind[w_gidx];
                    r_ptr <= w_gidx;
                end
            end
        end
    end

    assign bus.evt_valid_out  = r_valid;
    assign bus.evt_id_out     = r_id;
    assign bus.evt_repeat_out = r_rep;
    assign bus.dropped_out    = r_drop;
endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler: directed stimulus pushes expected
// events; a negedge monitor pops and compares each transfer.
module tb_button_event_scheduler;
    localparam int F = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_event_scheduler_if #(.FIELDS(F)) bus();

    button_event_scheduler #(
        .FIELDS        (F),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (8)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    typedef struct {
        int id;
        int rep;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   drops  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every transfer must match the head of the queue; stalled beats must hold.
    initial begin
        logic       pv, pr;
        logic [1:0] pid;
        exp_t       e;
        pv = 1'b0; pr = 1'b0; pid = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (bus.dropped_out) drops++;
                if (pv && !pr) begin
                    checks++;
                    if (!bus.evt_valid_out || bus.evt_id_out != pid) begin
                        errors++;
                        $display("FAIL hold_stable cyc=%0d got valid=%0d id=%0d want valid=1 id=%0d",
                                 cyc, bus.evt_valid_out, bus.evt_id_out, pid);
                    end
                end
                if (bus.evt_valid_out && bus.evt_ready_in) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_evt cyc=%0d got id=%0d rep=%0d want none",
                                 cyc, bus.evt_id_out, bus.evt_repeat_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(bus.evt_id_out) != e.id || int'(bus.evt_repeat_out) != e.rep ||
                            (e.cyc >= 0 && cyc != e.cyc)) begin
                            errors++;
                            $display("FAIL evt cyc=%0d got id=%0d rep=%0d want id=%0d rep=%0d cyc=%0d",
                                     cyc, bus.evt_id_out, bus.evt_repeat_out, e.id, e.rep, e.cyc);
                        end
                    end
                end
                pv  = bus.evt_valid_out;
                pr  = bus.evt_ready_in;
                pid = bus.evt_id_out;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [F-1:0] p);
        bus.pulses_in = p;
        tick();
        bus.pulses_in = '0;
    endtask

    task automatic push(input int id, input int rep, input int c);
        exp_t e;
        e.id = id; e.rep = rep; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, req);
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        tick(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.pulses_in = '0; bus.held_in = '0; bus.mask_in = '0; bus.evt_ready_in = 1'b0;
        tick(2);
        exp_q.delete();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d0;
        bus.pulses_in = '0; bus.held_in = '0; bus.mask_in = '0; bus.evt_ready_in = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", bus.evt_valid_out, 0);
        check("rst_id", bus.evt_id_out, 0);
        check("rst_repeat", bus.evt_repeat_out, 0);
        check("rst_dropped", bus.dropped_out, 0);

        // Single press: two-cycle latency
        bus.evt_ready_in = 1'b1;
        k = cyc;
        push(2, 0, k + 2);
        pulse(4'b0100);
        drain(10);

        // Simultaneous presses, twice: RR from reset pointer, then from pointer 3
        do_reset();
        bus.evt_ready_in = 1'b1;
        for (int r = 0; r < 2; r++) begin
            k = cyc;
            push(0, 0, k + 2); push(1, 0, k + 3); push(3, 0, k + 4);
            pulse(4'b1011);
            drain(10);
        end

        // Backpressure and drop: output busy with id0, bit1 pressed twice
        do_reset();
        d0 = drops;
        pulse(4'b0001);
        pulse(4'b0010);
        tick(4);
        check("stall_valid", bus.evt_valid_out, 1);
        check("stall_id", bus.evt_id_out, 0);
        pulse(4'b0010);
        check("drop_pulse", bus.dropped_out, 1);
        tick(3);
        check("drop_count", drops - d0, 1);
        push(0, 0, -1); push(1, 0, -1);
        bus.evt_ready_in = 1'b1;
        drain(10);

        // Auto-repeat: held 50 cycles -> repeats at hold cycles 20,28,36,44
        do_reset();
        bus.evt_ready_in = 1'b1;
        d0 = drops;
        k = cyc;
        bus.held_in = 4'b0001;
        push(0, 1, k + 21); push(0, 1, k + 29); push(0, 1, k + 37); push(0, 1, k + 45);
        tick(50);
        bus.held_in = '0;
        drain(20);
        tick(30);
        check("repeat_no_drop", drops - d0, 0);

        // Mask clears a pending press; unmask then press delivers
        do_reset();
        d0 = drops;
        pulse(4'b0001);
        pulse(4'b1000);
        tick(3);
        bus.mask_in = 4'b1000;
        pulse(4'b1000);
        tick(2);
        bus.mask_in = '0;
        check("mask_no_drop", drops - d0, 0);
        push(0, 0, -1);
        bus.evt_ready_in = 1'b1;
        drain(10);
        k = cyc;
        push(3, 0, k + 2);
        pulse(4'b1000);
        drain(10);

        // Async reset mid-burst, then pointer and latency back to reset behaviour
        do_reset();
        bus.evt_ready_in = 1'b1;
        k = cyc;
        push(0, 0, k + 2); push(1, 0, k + 3); push(2, 0, k + 4); push(3, 0, k + 5);
        pulse(4'b1111);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", bus.evt_valid_out, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        k = cyc;
        push(0, 0, k + 2); push(3, 0, k + 3);
        pulse(4'b1001);
        drain(10);
        k = cyc;
        push(0, 0, k + 2);
        pulse(4'b0001);
        drain(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
